multiplicador_param: RTL

//   Parametrised sequential shift-add multiplier: control FSM, accumulator, multiplier

---
 rtl/multiplicador_param_if.sv | 27 ++
 rtl/multiplicador_param.sv | 115 +++++++++++
 2 files changed

// File: rtl/multiplicador_param_if.sv
`default_nettype none
// ============================================================================
// Module      : multiplicador_param_if
// Description : Start/done request bus for the shift-add multiplier.
// Revision    : 1.0 - initial release
// ============================================================================
interface multiplicador_param_if #(
  parameter int WIDTH = 8
);
  logic                 start;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   product;

  modport master (
    output start, a, b,
    input  busy, done, product
  );

  modport slave (
    input  start, a, b,
    output busy, done, product
  );
endinterface
`default_nettype wire

// File: rtl/multiplicador_param.sv
`default_nettype none
// ============================================================================
// Module      : multiplicador_param
// Description : Sequential shift-add multiplier, product = a * b, 2*WIDTH bits.
//               Define SIGNED_MUL_EN for two's-complement operands and product.
// Revision    : 1.0 - initial release
// ============================================================================
module multiplicador_param #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  multiplicador_param_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  localparam logic [2:0] c_IDLE  = 3'd0;
  localparam logic [2:0] c_LOAD  = 3'd1;
  localparam logic [2:0] c_EVAL  = 3'd2;
  localparam logic [2:0] c_ADD   = 3'd3;
  localparam logic [2:0] c_SHIFT = 3'd4;
  localparam logic [2:0] c_DONE  = 3'd5;

  logic [2:0]       r_state;
  logic [WIDTH-1:0] r_m;
  logic [WIDTH:0]   r_a;
  logic [WIDTH-1:0] r_q;
  logic [CNT_W-1:0] r_cnt;

  logic [WIDTH-1:0] w_a_ld;
  logic [WIDTH-1:0] w_b_ld;

`ifdef SIGNED_MUL_EN
  localparam logic [2:0] c_NEG  = 3'd6;
  localparam logic [2:0] c_LAST = c_NEG;

  logic                 r_neg;
  logic [2*WIDTH-1:0]   w_prod_neg;

  // Magnitudes: -2^(W-1) wraps to 2^(W-1), which is still correct as unsigned.
  assign w_a_ld     = bus.a[WIDTH-1] ? -bus.a : bus.a;
  assign w_b_ld     = bus.b[WIDTH-1] ? -bus.b : bus.b;
  assign w_prod_neg = -{r_a[WIDTH-1:0], r_q};
`else
  localparam logic [2:0] c_LAST = c_DONE;

  assign w_a_ld = bus.a;
  assign w_b_ld = bus.b;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= c_IDLE;
      r_m     <= '0;
      r_a     <= '0;
      r_q     <= '0;
      r_cnt   <= '0;
`ifdef SIGNED_MUL_EN
      r_neg   <= 1'b0;
`endif
    end else begin
      case (r_state)
        c_IDLE: begin
          if (bus.start) r_state <= c_LOAD;
        end
        c_LOAD: begin
          r_m     <= w_a_ld;
          r_q     <= w_b_ld;
          r_a     <= '0;
          r_cnt   <= CNT_W'(WIDTH);
`ifdef SIGNED_MUL_EN
          r_neg   <= bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
`endif
          r_state <= c_EVAL;
        end
        c_EVAL: begin
          r_state <= r_q[0] ? c_ADD : c_SHIFT;
        end
        c_ADD: begin
          r_a     <= {1'b0, r_a[WIDTH-1:0]} + {1'b0, r_m};
          r_state <= c_SHIFT;
        end
        c_SHIFT: begin
          // The add carry in r_a[WIDTH] drops into the top of the product here.
          r_a     <= {1'b0, r_a[WIDTH:1]};
          r_q     <= {r_a[0], r_q[WIDTH-1:1]};
          r_cnt   <= r_cnt - CNT_W'(1);
          r_state <= (r_cnt == CNT_W'(1)) ? c_LAST : c_EVAL;
        end
`ifdef SIGNED_MUL_EN
        c_NEG: begin
          if (r_neg) begin
            r_a <= {1'b0, w_prod_neg[2*WIDTH-1:WIDTH]};
            r_q <= w_prod_neg[WIDTH-1:0];
          end
          r_state <= c_DONE;
        end
`endif
        c_DONE: begin
          if (!bus.start) r_state <= c_IDLE;
        end
        default: begin
          r_state <= c_IDLE;
        end
      endcase
    end
  end

  assign bus.busy    = (r_state != c_IDLE) && (r_state != c_DONE);
  assign bus.done    = (r_state == c_DONE);
  assign bus.product = {r_a[WIDTH-1:0], r_q};

endmodule
`default_nettype wire
